led_bank_ctrl: RTL and testbench
================================

# led_bank_ctrl

Parametrised N-channel status-LED controller for the backplane CPLD; successor to the fixed two-LED health/fault LED blocks. Sits behind the I2C slave register file: each LED owns a 4-bit mode code (two codes per register byte) and the block drives phase-aligned ON/OFF/blink patterns, a heartbeat and a self-expiring LOCATE mode, plus a global lamp test.

## Interface
- NUM_LED, 4: LED channel count, 1..32.
- REG_BASE, 8'h20: register address of the byte holding LED0/LED1.
- TICK_DIV, 1_562_500: SYSCLK cycles per base tick (16 Hz at 25 MHz). Minimum 2.
- LOCATE_TICKS, 48: LOCATE duration in base ticks (3 s). Range 1..255.
- RST_CODE, 4'h0: mode code loaded at reset.
- ACTIVE_LOW, 0: NUM_LED-bit mask; a set bit inverts that channel's output.
- SYSCLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- wr_en  in  1  single-cycle register write strobe.
- wr_addr  in  8  write byte address.
- wr_data  in  8  write data; [3:0] even LED, [7:4] odd LED.
- rd_addr  in  8  read byte address.
- rd_data  out  8  combinational read data.
- rd_hit  out  1  rd_addr within this block's range.
- lamp_test  in  1  level; forces all LEDs active.
- led_o  out  NUM_LED  registered LED drive, polarity per ACTIVE_LOW.

## Operation
- Address map: byte k = REG_BASE+k, k in 0..ceil(NUM_LED/2)-1. Codes: LED 2k in [3:0], LED 2k+1 in [7:4]. Writes outside the range are ignored. Nibbles for a nonexistent odd LED are written as 0 and read as 0.
- Codes:
  - 0 OFF.
  - 1 ON.
  - 2 BLK_1HZ.
  - 3 BLK_2HZ.
  - 4 BLK_4HZ.
  - 5 BLK_8HZ.
  - 6 HEARTBEAT: on during phase values 0 and 2, i.e. two ticks on per 16.
  - 7 LOCATE.
  - 8..15 are stored and read back but drive OFF.
- Phase counter ph[3:0] increments on every base tick and wraps 15->0. All channels share it, so blinks are phase-aligned and are not restarted by a write.
- Blink active level: BLK_8HZ = ph[0]. BLK_4HZ = ph[1]. BLK_2HZ = ph[2]. BLK_1HZ = ph[3].
- LOCATE, per channel:
  - Writing 7 saves the prior code into a per-channel saved register and loads cnt=LOCATE_TICKS.
  - While locating, the channel drives BLK_4HZ.
  - cnt decrements on each tick. When cnt reaches 0 the code reverts to the saved code, in the same cycle as that tick.
  - Rewriting 7 while locating reloads cnt and keeps the original saved code.
  - Writing any other code while locating cancels LOCATE; the new code wins.
  - Readback shows 7 while locating.
- lamp_test=1 forces every channel active, overriding all codes. Codes and counters keep running underneath.
- Output: led_o[i] = active ^ ACTIVE_LOW[i].
- Reset values:
  - all codes = RST_CODE; saved codes = 0.
  - cnt = 0; ph = 0; prescaler = 0.
  - led_o = ACTIVE_LOW. This is the inactive level for a non-ACTIVE code; if RST_CODE is an active code, the first clock after reset release applies it.

## Timing
- Write at edge T updates the code at T+1. led_o reflects the new code at edge T+2.
- rd_data follows the code register combinationally: the new value is visible from T+1.
- Base tick: a one-cycle pulse when the prescaler reaches TICK_DIV-1; the prescaler then returns to 0. The first tick occurs TICK_DIV cycles after reset release.
- Writes to the same channel in a tick cycle:
  - write of 7: reload wins over decrement.
  - write of another code during the expiry tick: the written code wins over the revert.
- lamp_test assert or deassert reaches led_o one cycle later.
- Reset asserted mid-LOCATE: the channel immediately returns to the reset state; LOCATE is not resumed.

## Structure
- Package led_bank_pkg holds:
  - code localparams (LED_OFF..LED_LOCATE);
  - the function mapping (code, ph) -> active.
- Sub-module led_tick_gen (TICK_DIV): prescaler, tick pulse and ph counter. It is shared and may be instantiated once per design.
- Per-channel state (code, saved, cnt) lives in a generate loop in led_bank_ctrl.

## Test plan
All scenarios use NUM_LED=4, TICK_DIV=4, LOCATE_TICKS=3, ACTIVE_LOW=4'b0010.
1. Reset: hold RESET_N=0 -> led_o=4'b0010 and rd_data@8'h20=00. Release; write 8'h20=8'h10 -> LED1 on two cycles later, so led_o[1]=0; LED0 off.
2. Blink: write 8'h20=8'h54 and 8'h21=8'h32 -> LED0 toggles every 2 ticks (8 cycles), LED1 every tick, LED2 every 8 ticks, LED3 every 4 ticks. All edges coincide with tick+1.
3. LOCATE:
   - Write 8'h20 low nibble 1, then 7 -> readback 7 and LED0 blinks at 4 Hz; after exactly 3 ticks it reverts to ON and readback 1.
   - Rewrite 7 mid-locate -> the 3-tick window restarts and the revert is still to 1.
4. Cancel and collision: during LOCATE, write code 0 in the expiry tick cycle -> code 0 and LED0 off; no revert to 1.
5. Lamp test: all codes 0, lamp_test=1 -> led_o=4'b1101 one cycle later; deassert restores 4'b0010.
6. Range: write 8'h22 and 8'h1F -> no state change; rd_hit=0 and rd_data=0 for those addresses. Write 8'h21=8'hFF -> led_o[3:2] inactive; readback FF.

Source files
------------

// File: rtl/led_bank_pkg.sv
// Shared mode codes and the (code, phase) -> active mapping for the LED bank.
package led_bank_pkg;

  localparam logic [3:0] LED_OFF       = 4'd0;
  localparam logic [3:0] LED_ON        = 4'd1;
  localparam logic [3:0] LED_BLK_1HZ   = 4'd2;
  localparam logic [3:0] LED_BLK_2HZ   = 4'd3;
  localparam logic [3:0] LED_BLK_4HZ   = 4'd4;
  localparam logic [3:0] LED_BLK_8HZ   = 4'd5;
  localparam logic [3:0] LED_HEARTBEAT = 4'd6;
  localparam logic [3:0] LED_LOCATE    = 4'd7;

  // Codes 8..15 are storage-only and fall through to OFF.
  function automatic logic led_active(input logic [3:0] code, input logic [3:0] ph);
    logic act;
    act = 1'b0;
    case (code)
      LED_ON:        act = 1'b1;
      LED_BLK_1HZ:   act = ph[3];
      LED_BLK_2HZ:   act = ph[2];
      LED_BLK_4HZ:   act = ph[1];
      LED_BLK_8HZ:   act = ph[0];
      LED_HEARTBEAT: act = (ph == 4'd0) || (ph == 4'd2);
      LED_LOCATE:    act = ph[1];
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler and 4-bit shared blink phase counter.
// tick_o is a one-cycle pulse while the prescaler sits at TICK_DIV-1.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 1_562_500
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  output logic       tick_o,
  output logic [3:0] ph_o
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ph_q, ph_d;

  assign tick_o = (presc_q == PW'(TICK_DIV - 1));
  assign ph_o   = ph_q;

  always_comb begin
    presc_d = presc_q + PW'(1);
    ph_d    = ph_q;
    if (tick_o) begin
      presc_d = '0;
      ph_d    = ph_q + 4'd1;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      ph_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ph_q    <= ph_d;
    end
  end

endmodule

// File: rtl/led_bank_ctrl.sv
// N-channel status-LED controller: per-channel 4-bit mode codes behind a byte register map,
// phase-aligned blinks, heartbeat, self-expiring LOCATE and a global lamp test.
module led_bank_ctrl
  import led_bank_pkg::*;
#(
  parameter int unsigned          NUM_LED      = 4,
  parameter logic [7:0]           REG_BASE     = 8'h20,
  parameter int unsigned          TICK_DIV     = 1_562_500,
  parameter int unsigned          LOCATE_TICKS = 48,
  parameter logic [3:0]           RST_CODE     = 4'h0,
  parameter logic [NUM_LED-1:0]   ACTIVE_LOW   = '0
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic               wr_en,
  input  logic [7:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [7:0]         rd_addr,
  output logic [7:0]         rd_data,
  output logic               rd_hit,
  input  logic               lamp_test,
  output logic [NUM_LED-1:0] led_o
);

  localparam int unsigned NUM_REG = (NUM_LED + 1) / 2;
  localparam int unsigned NUM_PAD = NUM_REG * 2;

  logic                    tick;
  logic [3:0]              ph;
  logic [7:0]              wr_off, rd_off;
  logic                    wr_hit;
  logic [NUM_LED-1:0][3:0] code_vec;
  logic [NUM_PAD-1:0][3:0] code_pad;
  logic [NUM_LED-1:0]      act;
  logic [NUM_LED-1:0]      led_q, led_d;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .tick_o  (tick),
    .ph_o    (ph)
  );

  // Offset arithmetic wraps, so addresses below REG_BASE land far out of range.
  assign wr_off = wr_addr - REG_BASE;
  assign rd_off = rd_addr - REG_BASE;
  assign wr_hit = wr_en && (wr_off < 8'(NUM_REG));
  assign rd_hit = (rd_off < 8'(NUM_REG));

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    logic [3:0] code_q, code_d;
    logic [3:0] saved_q, saved_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel;
    logic [3:0] wcode;

    assign sel   = wr_hit && (wr_off == 8'(i / 2));
    assign wcode = (i % 2 == 1) ? wr_data[7:4] : wr_data[3:0];

    // A write always beats the tick: a 7 reloads, anything else cancels LOCATE.
    always_comb begin
      code_d  = code_q;
      saved_d = saved_q;
      cnt_d   = cnt_q;
      if (sel) begin
        if (wcode == LED_LOCATE) begin
          if (cnt_q == 8'd0) begin
            saved_d = code_q;
          end
          cnt_d  = 8'(LOCATE_TICKS);
          code_d = LED_LOCATE;
        end else begin
          code_d = wcode;
          cnt_d  = 8'd0;
        end
      end else if (tick && (cnt_q != 8'd0)) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          code_d = saved_q;
        end
      end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        code_q  <= RST_CODE;
        saved_q <= 4'd0;
        cnt_q   <= 8'd0;
      end else begin
        code_q  <= code_d;
        saved_q <= saved_d;
        cnt_q   <= cnt_d;
      end
    end

    assign code_vec[i] = code_q;
    assign act[i]      = led_active(code_q, ph);
  end

  always_comb begin
    code_pad              = '0;
    code_pad[NUM_LED-1:0] = code_vec;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < int'(NUM_REG); k++) begin
      if (rd_off == 8'(k)) begin
        rd_data = {code_pad[2*k+1], code_pad[2*k]};
      end
    end
  end

  assign led_d = (act | {NUM_LED{lamp_test}}) ^ ACTIVE_LOW;
  assign led_o = led_q;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q <= ACTIVE_LOW;
    end else begin
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Directed bench for led_bank_ctrl: static vector table, then blink, LOCATE,
// collision, lamp-test and reset sequences with hand-derived expectations.
module tb_led_bank_ctrl;

  logic       SYSCLK = 1'b0;
  logic       RESET_N;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       rd_hit, lamp_test;
  logic [3:0] led_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 SYSCLK = ~SYSCLK;

  led_bank_ctrl #(
    .NUM_LED(4), .REG_BASE(8'h20), .TICK_DIV(4), .LOCATE_TICKS(3),
    .RST_CODE(4'h0), .ACTIVE_LOW(4'b0010)
  ) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
    .lamp_test(lamp_test), .led_o(led_o)
  );

  typedef struct {
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic       lt;
    logic [7:0] erd;
    logic       ehit;
    logic [3:0] eled;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge SYSCLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Phase held by the DUT after post-release edge n (ticks land on every 4th edge).
  function automatic logic [3:0] ph_at(input int n);
    return 4'((n / 4) % 16);
  endfunction

  function automatic logic exp_act(input logic [3:0] code, input logic [3:0] ph);
    case (code)
      4'd1:    return 1'b1;
      4'd2:    return ph[3];
      4'd3:    return ph[2];
      4'd4:    return ph[1];
      4'd5:    return ph[0];
      4'd6:    return (ph == 4'd0) || (ph == 4'd2);
      4'd7:    return ph[1];
      default: return 1'b0;
    endcase
  endfunction

  // LED0 code after edge n: LOCATE inside [es, r), otherwise the saved ON code.
  function automatic logic [3:0] code_at(input int n, input int es, input int r);
    return (n >= es && n < r) ? 4'd7 : 4'd1;
  endfunction

  task automatic run_locate(input int es, input int r, input int upto);
    logic [3:0] want;
    while (cyc < upto) begin
      chk("loc_rd", rd_data, {4'h0, code_at(cyc, es, r)});
      want = {2'b00, 1'b1, exp_act(code_at(cyc - 1, es, r), ph_at(cyc - 1))};
      chk("loc_led", {4'h0, led_o}, {4'h0, want});
      step();
    end
  endtask

  initial begin
    int e, e2, r, r2;
    logic [3:0] bw;

    tbl[0]  = '{1'b1, 8'h20, 8'h10, 8'h20, 1'b0, 8'h10, 1'b1, 4'b0000};
    tbl[1]  = '{1'b1, 8'h20, 8'h01, 8'h20, 1'b0, 8'h01, 1'b1, 4'b0011};
    tbl[2]  = '{1'b1, 8'h21, 8'h11, 8'h21, 1'b0, 8'h11, 1'b1, 4'b1111};
    tbl[3]  = '{1'b1, 8'h21, 8'h98, 8'h21, 1'b0, 8'h98, 1'b1, 4'b0011};
    tbl[4]  = '{1'b1, 8'h22, 8'hFF, 8'h22, 1'b0, 8'h00, 1'b0, 4'b0011};
    tbl[5]  = '{1'b1, 8'h1F, 8'hFF, 8'h1F, 1'b0, 8'h00, 1'b0, 4'b0011};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'h20, 1'b0, 8'h01, 1'b1, 4'b0011};
    tbl[7]  = '{1'b1, 8'h20, 8'h00, 8'h21, 1'b0, 8'h98, 1'b1, 4'b0010};
    tbl[8]  = '{1'b0, 8'h00, 8'h00, 8'h20, 1'b1, 8'h00, 1'b1, 4'b1101};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'h20, 1'b0, 8'h00, 1'b1, 4'b0010};
    tbl[10] = '{1'b1, 8'h21, 8'hFF, 8'h21, 1'b0, 8'hFF, 1'b1, 4'b0010};
    tbl[11] = '{1'b1, 8'h21, 8'h00, 8'h21, 1'b0, 8'h00, 1'b1, 4'b0010};

    RESET_N = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    rd_addr = 8'h20; lamp_test = 1'b0;
    repeat (3) step();
    chk("rst_led", {4'h0, led_o}, 8'h02);
    chk("rst_rd", rd_data, 8'h00);
    chk("rst_hit", {7'h0, rd_hit}, 8'h01);
    RESET_N = 1'b1;
    cyc = 0;

    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr = tbl[i].ra; lamp_test = tbl[i].lt;
      step();
      wr_en = 1'b0;
      step();
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].erd);
      chk($sformatf("tbl%0d_hit", i), {7'h0, rd_hit}, {7'h0, tbl[i].ehit});
      chk($sformatf("tbl%0d_led", i), {4'h0, led_o}, {4'h0, tbl[i].eled});
    end

    // Lamp test lands exactly one edge later, in both directions.
    lamp_test = 1'b1;
    chk("lamp_pre", {4'h0, led_o}, 8'h02);
    step();
    chk("lamp_on", {4'h0, led_o}, 8'h0D);
    lamp_test = 1'b0;
    step();
    chk("lamp_off", {4'h0, led_o}, 8'h02);

    // Blinks: LED0=4Hz, LED1=8Hz, LED2=1Hz, LED3=2Hz, all from the shared phase.
    wr(8'h20, 8'h54);
    wr(8'h21, 8'h32);
    for (int k = 0; k < 70; k++) begin
      step();
      bw = {exp_act(4'd3, ph_at(cyc - 1)), exp_act(4'd2, ph_at(cyc - 1)),
            exp_act(4'd5, ph_at(cyc - 1)), exp_act(4'd4, ph_at(cyc - 1))} ^ 4'b0010;
      chk("blink", {4'h0, led_o}, {4'h0, bw});
    end

    // LOCATE from ON: three ticks of 4 Hz blink, then back to ON.
    wr(8'h21, 8'h00);
    wr(8'h20, 8'h01);
    rd_addr = 8'h20;
    step(); step();
    wr(8'h20, 8'h07);
    e = cyc;
    r = (e / 4 + 1) * 4 + 8;
    run_locate(e, r, r + 4);

    // Rewriting 7 mid-locate restarts the window and keeps the saved ON code.
    wr(8'h20, 8'h07);
    e = cyc;
    r = (e / 4 + 1) * 4 + 8;
    run_locate(e, r, e + 5);
    wr(8'h20, 8'h07);
    e2 = cyc;
    r2 = (e2 / 4 + 1) * 4 + 8;
    run_locate(e, r2, r2 + 4);

    // A write of 0 in the expiry tick cycle beats the revert.
    wr(8'h20, 8'h07);
    e = cyc;
    r = (e / 4 + 1) * 4 + 8;
    run_locate(e, r, r - 1);
    wr(8'h20, 8'h00);
    chk("coll_tick", {7'h0, (cyc % 4 == 0)}, 8'h01);
    chk("coll_rd", rd_data, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("coll_rd_hold", rd_data, 8'h00);
      chk("coll_led", {4'h0, led_o}, 8'h02);
    end

    // Reset mid-LOCATE drops straight to reset state and stays there.
    wr(8'h20, 8'h01);
    wr(8'h20, 8'h07);
    step();
    RESET_N = 1'b0;
    #1;
    chk("rstloc_rd", rd_data, 8'h00);
    chk("rstloc_led", {4'h0, led_o}, 8'h02);
    step();
    RESET_N = 1'b1;
    cyc = 0;
    repeat (20) step();
    chk("rstloc_rd_after", rd_data, 8'h00);
    chk("rstloc_led_after", {4'h0, led_o}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
